// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit: size codes, FSM states,
// lane shifts and the latched request payload.
package mem_access_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam int unsigned LANE_BYTE_SH = 3;
    localparam int unsigned LANE_HALF_SH = 4;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              uns;
        logic [1:0]        lo;
        logic [DATA_W-1:0] wdata;
    } req_lat_t;

    // Reserved size code behaves as a word access
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return ((size == SZ_BYTE) || (size == SZ_HALF)) ? size : SZ_WORD;
    endfunction

    // Bit offset of the addressed lane; low bits below the access size are dropped
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 5'(lo) << LANE_BYTE_SH;
            SZ_HALF: return 5'(lo[1]) << LANE_HALF_SH;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake plus single-port word memory bus of the access unit.
interface mem_access_if #(
    parameter int unsigned AW = 32
);
    logic          Req_Valid;
    logic          Req_Ready;
    logic          Req_Write;
    logic [1:0]    Req_Size;
    logic          Req_Unsigned;
    logic [AW-1:0] Req_Addr;
    logic [31:0]   Req_Wdata;
    logic          Rsp_Valid;
    logic          Rsp_Ready;
    logic [31:0]   Rsp_Rdata;
    logic          Rsp_Err;
    logic          Mem_We;
    logic [31:0]   Mem_Addr;
    logic [31:0]   Mem_Wd;
    logic [31:0]   Mem_Rd;

    modport slave (
        input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_Wdata,
        input  Rsp_Ready, Mem_Rd,
        output Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err, Mem_We, Mem_Addr, Mem_Wd
    );

    modport master (
        output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_Wdata,
        output Rsp_Ready, Mem_Rd,
        input  Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err, Mem_We, Mem_Addr, Mem_Wd
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data_c,
    output logic [31:0] st_data_c
);

    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh        = lane_shift(size, lo);
        lane      = 16'(rd >> sh);
        mask      = '1;
        ld_data_c = rd;
        case (size)
            SZ_BYTE: begin
                mask      = 32'h0000_00FF << sh;
                ld_data_c = {{24{~uns & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                mask      = 32'h0000_FFFF << sh;
                ld_data_c = {{16{~uns & lane[15]}}, lane[15:0]};
            end
            default: ;
        endcase
        st_data_c = (rd & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator for a single-port word memory.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = 32
) (
    input  logic         Clk,
    input  logic         Rst_n,
    mem_access_if.slave  bus
);

    localparam logic [AW-1:0] DEPTH_IDX = AW'(DEPTH_WORDS);

    state_t      state, state_nxt;
    req_lat_t    lat, lat_nxt;
    logic        req_ready_q, rsp_valid_q, mem_we_q;
    logic        rsp_err_q, rsp_err_nxt;
    logic [31:0] rsp_rdata_q, rsp_rdata_nxt;
    logic [31:0] mem_addr_q, mem_addr_nxt;
    logic [31:0] mem_wd_q, mem_wd_nxt;
    logic [1:0]  req_size_c;
    logic        range_err_c, misalign_c;
    logic [31:0] ld_data_c, st_data_c;

    assign req_size_c  = norm_size(bus.Req_Size);
    assign range_err_c = (bus.Req_Addr >> 2) >= DEPTH_IDX;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_c = ((req_size_c == SZ_HALF) && bus.Req_Addr[0]) ||
                        ((req_size_c == SZ_WORD) && (bus.Req_Addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    mem_lane_align u_align (
        .rd        (bus.Mem_Rd),
        .lo        (lat.lo),
        .size      (lat.size),
        .uns       (lat.uns),
        .wdata     (lat.wdata),
        .ld_data_c (ld_data_c),
        .st_data_c (st_data_c)
    );

    // Next state and next values of all registered outputs
    always_comb begin
        state_nxt     = state;
        lat_nxt       = lat;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_err_nxt   = rsp_err_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wd_nxt    = mem_wd_q;
        case (state)
            ST_IDLE: begin
                if (bus.Req_Valid) begin
                    lat_nxt.write = bus.Req_Write;
                    lat_nxt.size  = req_size_c;
                    lat_nxt.uns   = bus.Req_Unsigned;
                    lat_nxt.lo    = bus.Req_Addr[1:0];
                    lat_nxt.wdata = bus.Req_Wdata;
                    mem_addr_nxt  = 32'(bus.Req_Addr >> 2);
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                    if (range_err_c || misalign_c) begin
                        rsp_err_nxt = 1'b1;
                        state_nxt   = ST_RESP;
                    end else if (bus.Req_Write && (req_size_c == SZ_WORD)) begin
                        mem_wd_nxt = bus.Req_Wdata;
                        state_nxt  = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (lat.write) begin
                    mem_wd_nxt = st_data_c;
                    state_nxt  = ST_WRITE;
                end else begin
                    rsp_rdata_nxt = ld_data_c;
                    state_nxt     = ST_RESP;
                end
            end
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.Rsp_Ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and write-enable flags are decoded from the next state so they
    // line up with the state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            lat         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
        end else begin
            state       <= state_nxt;
            lat         <= lat_nxt;
            req_ready_q <= (state_nxt == ST_IDLE);
            rsp_valid_q <= (state_nxt == ST_RESP);
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_err_q   <= rsp_err_nxt;
            mem_we_q    <= (state_nxt == ST_WRITE);
            mem_addr_q  <= mem_addr_nxt;
            mem_wd_q    <= mem_wd_nxt;
        end
    end

    assign bus.Req_Ready = req_ready_q;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_Rdata = rsp_rdata_q;
    assign bus.Rsp_Err   = rsp_err_q;
    assign bus.Mem_We    = mem_we_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_Wd    = mem_wd_q;

endmodule
